// File: rtl/hpu_pkg.sv
// Shared types for the flag drain block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hpu_pkg;

  // Drain pass sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_REQ  = 3'd2,
    ST_CLR  = 3'd3,
    ST_DONE = 3'd4
  } drain_state_t;

endpackage : hpu_pkg

// File: rtl/flag_drain.sv
// Walks an external per-index flag register once per pass, raising a request for
// every set flag and clearing it after the consumer accepts.
// Latency: 1 cycle per unset index, request+2 cycles per set index; done_o DWTH+1
// cycles after start_i on an empty register.
// Backpressure: req_valid_o/req_idx_o hold in REQ until req_ready_i; abort_i wins.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, abort_i      begin a pass (ignored while busy) / terminate a pass
//   raddr_o, rdata_i      combinational read port of the flag register
//   clr_en_o, clr_addr_o  one-cycle clear strobe to the flag register
//   req_valid_o, req_idx_o, req_ready_i   drain request handshake
//   busy_o, done_o, count_o               pass status
module flag_drain #(
  parameter int DWTH = 8,
  parameter int AWTH = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  output logic [AWTH-1:0] raddr_o,
  input  logic            rdata_i,
  output logic            clr_en_o,
  output logic [AWTH-1:0] clr_addr_o,
  output logic            req_valid_o,
  output logic [AWTH-1:0] req_idx_o,
  input  logic            req_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [AWTH:0]   count_o
);
  import hpu_pkg::*;

  localparam logic [AWTH-1:0] LAST_IDX = AWTH'(DWTH - 1);

  drain_state_t    r_state;
  logic [AWTH-1:0] r_ptr;
  logic [AWTH-1:0] r_idx;
  logic [AWTH:0]   r_count;

  drain_state_t    w_state_nxt;
  logic [AWTH-1:0] w_ptr_nxt;
  logic [AWTH-1:0] w_idx_nxt;
  logic [AWTH:0]   w_count_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_count <= w_count_nxt;
    end
  end

  // All outputs decode from registered state, so reset drops them immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_count;
    raddr_o     = '0;
    clr_en_o    = 1'b0;
    clr_addr_o  = '0;
    req_valid_o = 1'b0;
    req_idx_o   = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_ptr_nxt   = '0;
          w_count_nxt = '0;
          w_state_nxt = ST_SCAN;
        end
      end

      ST_SCAN: begin
        busy_o  = 1'b1;
        raddr_o = r_ptr;
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (rdata_i) begin
          w_idx_nxt   = r_ptr;
          w_state_nxt = ST_REQ;
        end else if (r_ptr == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_ptr_nxt = r_ptr + AWTH'(1);
        end
      end

      ST_REQ: begin
        busy_o      = 1'b1;
        req_valid_o = 1'b1;
        req_idx_o   = r_idx;
        // Abort beats a same-cycle accept; that request is not counted.
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (req_ready_i) begin
          w_count_nxt = r_count + (AWTH+1)'(1);
          w_state_nxt = ST_CLR;
        end
      end

      ST_CLR: begin
        busy_o     = 1'b1;
        clr_en_o   = 1'b1;
        clr_addr_o = r_idx;
        // Resume past idx so a same-cycle re-set of idx is left for the next pass.
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_ptr_nxt   = r_idx + AWTH'(1);
          w_state_nxt = ST_SCAN;
        end
      end

      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign count_o = r_count;

endmodule : flag_drain

// File: tb/tb_flag_drain.sv
// Self-checking bench for flag_drain with a behavioural flag register alongside.
// Latency: n/a.
// Backpressure: req_ready_i driven with random per-request hold-off.
module tb_flag_drain;
  localparam int DWTH = 8;
  localparam int AWTH = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [AWTH-1:0] raddr;
  logic            rdata;
  logic            clr_en;
  logic [AWTH-1:0] clr_addr;
  logic            req_valid;
  logic [AWTH-1:0] req_idx;
  logic            req_ready;
  logic            busy;
  logic            done;
  logic [AWTH:0]   count;

  always #5 clk = ~clk;

  flag_drain #(.DWTH(DWTH), .AWTH(AWTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .raddr_o(raddr), .rdata_i(rdata), .clr_en_o(clr_en), .clr_addr_o(clr_addr),
    .req_valid_o(req_valid), .req_idx_o(req_idx), .req_ready_i(req_ready),
    .busy_o(busy), .done_o(done), .count_o(count)
  );

  // Flag register: combinational read, clear strobe, external set wins over clear.
  logic [DWTH-1:0] flags;
  logic            load_vld;
  logic [DWTH-1:0] load_val;
  logic [DWTH-1:0] set_mask;
  logic [DWTH-1:0] clr_mask;
  assign clr_mask = clr_en ? (DWTH'(1) << clr_addr) : '0;
  assign rdata    = flags[raddr];
  always @(posedge clk) begin
    if (load_vld) flags <= load_val;
    else          flags <= (flags & ~clr_mask) | set_mask;
  end

  // Transaction monitor, sampled mid-cycle.
  int acc_q[$];
  int clr_q[$];
  int done_cnt;
  int rv_cnt;
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready && !abort) acc_q.push_back(int'(req_idx));
      if (clr_en) clr_q.push_back(int'(clr_addr));
      if (done) done_cnt++;
      if (req_valid) rv_cnt++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mon();
    acc_q.delete();
    clr_q.delete();
    done_cnt = 0;
    rv_cnt   = 0;
  endtask

  task automatic load_flags(input logic [DWTH-1:0] v);
    load_vld = 1'b1;
    load_val = v;
    tick();
    load_vld = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"},      32'(busy),      0);
    chk({tag, " done"},      32'(done),      0);
    chk({tag, " req_valid"}, 32'(req_valid), 0);
    chk({tag, " clr_en"},    32'(clr_en),    0);
    chk({tag, " raddr"},     32'(raddr),     0);
    chk({tag, " req_idx"},   32'(req_idx),   0);
    chk({tag, " clr_addr"},  32'(clr_addr),  0);
  endtask

  // Reference: a pass drains set flags in ascending index order. Each unset index
  // costs one cycle, each set index 3 cycles plus its ready hold-off, and done
  // follows one cycle after the start pulse plus those costs.
  task automatic run_pass(input logic [DWTH-1:0] pat, input int maxd, input string tag);
    int exp_q[$];
    int pc, cost, c0, got, dcur, wcnt, vcyc;
    bit in_req;
    load_flags(pat);
    clear_mon();
    pc = 0;
    for (int i = 0; i < DWTH; i++) if (pat[i]) begin exp_q.push_back(i); pc++; end
    cost = 1 + (DWTH - pc);
    vcyc = 0;
    got = -1; in_req = 0; dcur = 0; wcnt = 0;
    req_ready = 1'b0;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 400 && got < 0; k++) begin
      if (done) begin
        got = cyc;
      end else begin
        if (req_valid) begin
          if (!in_req) begin
            in_req = 1;
            dcur = $urandom_range(maxd, 0);
            cost += 3 + dcur;
            vcyc += 1 + dcur;
            wcnt = 0;
          end
          req_ready = (wcnt >= dcur);
          wcnt++;
        end else begin
          in_req = 0;
          req_ready = 1'b0;
        end
        tick();
      end
    end
    chk({tag, " done time"}, 32'(got), 32'(c0 + cost));
    chk({tag, " count"}, 32'(count), 32'(pc));
    req_ready = 1'b0;
    tick();
    chk({tag, " done pulse width"}, 32'(done), 0);
    chk({tag, " idle after done"}, 32'(busy), 0);
    chk({tag, " req cycles"}, 32'(rv_cnt), 32'(vcyc));
    chk({tag, " accept count"}, 32'(acc_q.size()), 32'(pc));
    chk({tag, " clear count"}, 32'(clr_q.size()), 32'(pc));
    for (int i = 0; i < pc && i < acc_q.size() && i < clr_q.size(); i++) begin
      chk({tag, " accept idx"}, 32'(acc_q[i]), 32'(exp_q[i]));
      chk({tag, " clear idx"},  32'(clr_q[i]), 32'(exp_q[i]));
    end
    chk({tag, " flags empty"}, 32'(flags), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; req_ready = 1'b0;
    load_vld = 1'b1; load_val = '0; set_mask = '0;
    clear_mon();
    #2;
    chk_quiet("reset");
    chk("reset count", 32'(count), 0);
    tick(); tick();
    rst = 1'b0;
    load_vld = 1'b0;
    tick();
    chk_quiet("post reset");

    // Fixed pattern with consumer always ready.
    run_pass(8'b1000_0101, 0, "p85");

    // Empty register: done exactly DWTH+1 cycles after start, no request.
    run_pass(8'h00, 0, "empty");

    // Stalled consumer: request held stable, clear the cycle after accept.
    load_flags(8'b0000_0010);
    clear_mon();
    req_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20 && !req_valid; k++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall valid", 32'(req_valid), 1);
      chk("stall idx", 32'(req_idx), 1);
      chk("stall no clr", 32'(clr_en), 0);
      tick();
    end
    req_ready = 1'b1;
    chk("stall valid at accept", 32'(req_valid), 1);
    tick();
    req_ready = 1'b0;
    chk("clr after accept", 32'(clr_en), 1);
    chk("clr addr", 32'(clr_addr), 1);
    chk("valid dropped", 32'(req_valid), 0);
    for (int k = 0; k < 20 && !done; k++) tick();
    chk("stall done", 32'(done), 1);
    chk("stall count", 32'(count), 1);
    tick();
    chk("stall flags", 32'(flags), 0);

    // Mid-pass sets: bit 6 lies ahead of the pointer, bit 1 behind it.
    load_flags(8'h00);
    clear_mon();
    req_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20 && !(busy && raddr == 3'd3); k++) tick();
    chk("ptr reached 3", 32'(raddr), 3);
    set_mask = 8'b0100_0010;
    tick();
    set_mask = '0;
    for (int k = 0; k < 20 && !done; k++) tick();
    chk("midset done", 32'(done), 1);
    chk("midset count", 32'(count), 1);
    chk("midset accepts", 32'(acc_q.size()), 1);
    chk("midset idx", 32'((acc_q.size() > 0) ? acc_q[0] : -1), 6);
    tick();
    req_ready = 1'b0;
    chk("midset flags", 32'(flags), 32'h02);

    // Abort in REQ on idx 4 together with ready; start while busy is ignored.
    load_flags(8'b0001_0001);
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20 && !req_valid; k++) tick();
    chk("abort first idx", 32'(req_idx), 0);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy start ignored", 32'(raddr), 1);
    chk("busy count kept", 32'(count), 1);
    for (int k = 0; k < 20 && !req_valid; k++) tick();
    chk("abort req idx", 32'(req_idx), 4);
    abort = 1'b1; req_ready = 1'b1;
    tick();
    abort = 1'b0; req_ready = 1'b0;
    chk_quiet("after abort");
    chk("abort count retained", 32'(count), 1);
    tick(); tick(); tick();
    chk("abort no done", 32'(done_cnt), 0);
    chk("abort bit4 kept", 32'(flags), 32'h10);
    chk("abort clears", 32'(clr_q.size()), 1);
    chk("abort accepts", 32'(acc_q.size()), 1);

    // Asynchronous reset while a request is pending.
    load_flags(8'b1000_0001);
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20 && !req_valid; k++) tick();
    chk("pre-reset valid", 32'(req_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk_quiet("async reset");
    chk("async reset count", 32'(count), 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("reset no clear", 32'(flags), 32'h81);
    chk("reset no resume", 32'(busy), 0);
    run_pass(8'b1000_0001, 2, "after reset");

    // Random patterns with random consumer hold-off.
    for (int t = 0; t < 20; t++) begin
      run_pass(DWTH'($urandom), 3, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_flag_drain
